// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core subsystem.
//
// Contents:
//   SIZE, ADDR_WIDTH   shared instruction/data BRAM geometry (32-bit words)
//   MAILBOX_ADDR       word address whose store marks program completion
//   PASS_CODE          mailbox value that means the program passed
//   ctrl_state_t       phases of the run controller
package riscv_pkg;

  localparam int SIZE       = 1024;
  localparam int ADDR_WIDTH = 10;

  localparam logic [ADDR_WIDTH-1:0] MAILBOX_ADDR = 10'h3FF;
  localparam logic [31:0]           PASS_CODE    = 32'h0000_0001;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HOLD    = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4,
    TIMEOUT = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/core_run_controller_bram_stream_loader.sv
// bram_stream_loader: accepts a host word stream with a valid/ready handshake
// and turns each accepted word into a registered BRAM port A write at the next
// sequential word address.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        arm a new load: index back to 0, length latched (clamped)
//   len          requested word count, sampled on start
//   active       controller is in its load phase; enables acceptance
//   valid, data  host stream word
//   ready        word is accepted this cycle when valid is also high
//   wr_addr      registered write address (load index of the accepted word)
//   wr_data      registered write data
//   wr_en        registered byte enables, 4'hF the cycle after an accept
//   done         combinational pulse on the accept of the final word
module bram_stream_loader #(
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  active,
  input  logic                  valid,
  input  logic [31:0]           data,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_en,
  output logic                  done
);
  import riscv_pkg::*;

  localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);

  // One bit wider than the address so a full-depth length fits.
  logic [ADDR_WIDTH:0]   idx_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  accept;
  logic [3:0]            wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;

  assign ready  = active;
  assign accept = active && valid;
  assign done   = accept && ((idx_q + ONE) == len_q);

  // Stage boundary: accepted word -> registered BRAM write
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      len_q   <= '0;
      wr_en_q <= 4'h0;
    end else begin
      if (start) begin
        idx_q <= '0;
        len_q <= (len > SIZE_W) ? SIZE_W : len;
      end else if (accept) begin
        idx_q <= idx_q + ONE;
      end
      wr_en_q <= accept ? 4'hF : 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_addr_q <= idx_q[ADDR_WIDTH-1:0];
      wr_data_q <= data;
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;

endmodule

// File: rtl/core_run_controller.sv
// core_run_controller: sequences one RISC-V core and its shared BRAM through
// program load, reset hold, run and completion. Sits between the core dmem
// port and BRAM port A.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_start                    pulse; begins a load from IDLE/DONE/TIMEOUT
//   i_load_len                 words to load (clamped to SIZE), sampled on i_start
//   i_load_valid/i_load_data   host word stream; o_load_ready is its ready
//   i_core_addr/_wr_data/_wr_en core dmem store port (word address)
//   o_bram_addr/_wr_data/_wr_en BRAM port A
//   o_core_reset               core reset, high except while running
//   o_busy                     in LOAD, HOLD or RUN
//   o_done/o_timeout/o_pass    sticky completion status
//   o_result                   captured mailbox value
//   o_cycle_count              run cycles, frozen when the run ends
module core_run_controller #(
  parameter int                          SIZE              = riscv_pkg::SIZE,
  parameter int                          ADDR_WIDTH        = riscv_pkg::ADDR_WIDTH,
  parameter int                          RESET_HOLD_CYCLES = 6,
  parameter logic [riscv_pkg::ADDR_WIDTH-1:0] MAILBOX_ADDR = riscv_pkg::MAILBOX_ADDR,
  parameter logic [31:0]                 PASS_CODE         = riscv_pkg::PASS_CODE,
  parameter int                          TIMEOUT_CYCLES    = 1_000_000,
  parameter int                          CNT_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_load_len,
  input  logic                  i_load_valid,
  input  logic [31:0]           i_load_data,
  output logic                  o_load_ready,
  input  logic [13:0]           i_core_addr,
  input  logic [31:0]           i_core_wr_data,
  input  logic [3:0]            i_core_wr_en,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [31:0]           o_bram_wr_data,
  output logic [3:0]            o_bram_wr_en,
  output logic                  o_core_reset,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic                  o_pass,
  output logic [31:0]           o_result,
  output logic [CNT_WIDTH-1:0]  o_cycle_count
);
  import riscv_pkg::*;

  localparam int                   HOLD_W       = $clog2(RESET_HOLD_CYCLES + 1) + 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  ctrl_state_t state_q, state_d;

  logic [HOLD_W-1:0]    hold_q;
  logic [CNT_WIDTH-1:0] cycle_q;
  logic                 done_q, timeout_q, pass_q, core_rst_q;
  logic [31:0]          result_q;

  logic                  load_start, load_active, use_loader;
  logic                  mbox_hit, wd_fire, busy;
  logic                  ld_done;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [31:0]           ld_data;
  logic [3:0]            ld_wr_en;

  // Upper core address bits lie outside the BRAM and are ignored.
  logic unused_core_addr;
  assign unused_core_addr = ^i_core_addr[13:ADDR_WIDTH];

  bram_stream_loader #(
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_loader (
    .clk     (clk),
    .reset   (reset),
    .start   (load_start),
    .len     (i_load_len),
    .active  (load_active),
    .valid   (i_load_valid),
    .data    (i_load_data),
    .ready   (o_load_ready),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .wr_en   (ld_wr_en),
    .done    (ld_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      core_rst_q <= (state_d != RUN);
    end
  end

  always_comb begin
    state_d     = state_q;
    load_start  = 1'b0;
    mbox_hit    = 1'b0;
    wd_fire     = 1'b0;
    load_active = (state_q == LOAD);
    busy        = (state_q == LOAD) || (state_q == HOLD) || (state_q == RUN);
    // The last loader write lands in the first HOLD cycle, so the port stays
    // with the loader until then.
    use_loader  = (state_q == LOAD) || ((state_q == HOLD) && (hold_q == '0));

    if (state_q == RUN) begin
      mbox_hit = (i_core_wr_en != 4'h0) &&
                 (i_core_addr[ADDR_WIDTH-1:0] == MAILBOX_ADDR);
      // A mailbox store on the final watchdog cycle takes priority.
      wd_fire  = !mbox_hit && (cycle_q == TIMEOUT_LAST);
    end

    case (state_q)
      IDLE, DONE, TIMEOUT: begin
        if (i_start) begin
          load_start = 1'b1;
          state_d    = (i_load_len == '0) ? HOLD : LOAD;
        end
      end
      LOAD:    if (ld_done) state_d = HOLD;
      HOLD:    if (hold_q == HOLD_LAST) state_d = RUN;
      RUN: begin
        if (mbox_hit)     state_d = DONE;
        else if (wd_fire) state_d = TIMEOUT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: hold/run counters and sticky status
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      cycle_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      hold_q <= ((state_q == HOLD) && (state_d == HOLD)) ? hold_q + HOLD_W'(1) : '0;
      if (load_start) begin
        cycle_q   <= '0;
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        pass_q    <= 1'b0;
        result_q  <= '0;
      end else if (mbox_hit) begin
        result_q <= i_core_wr_data;
        pass_q   <= (i_core_wr_data == PASS_CODE);
        done_q   <= 1'b1;
      end else if (wd_fire) begin
        timeout_q <= 1'b1;
      end else if (state_q == RUN) begin
        cycle_q <= sat_inc(cycle_q);
      end
    end
  end

  assign o_bram_addr    = use_loader ? ld_addr  : i_core_addr[ADDR_WIDTH-1:0];
  assign o_bram_wr_data = use_loader ? ld_data  : i_core_wr_data;
  assign o_bram_wr_en   = use_loader ? ld_wr_en : i_core_wr_en;

  assign o_core_reset  = core_rst_q;
  assign o_busy        = busy;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_pass        = pass_q;
  assign o_result      = result_q;
  assign o_cycle_count = cycle_q;

endmodule
